// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and fetch entry layout for the instruction fetch queue
package fetch_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // Entry layout: pc in [63:32], instruction in [31:0]
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO of fetch entries with push/pop/clear and registered head
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t pushData,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  // Storage is zeroed on reset so the head reads 0 until the first push
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (pop) rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rdPtr];

  a_no_push_full: assert property (@(posedge clk) disable iff (reset || clear)
    !(push && count == FULL));

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - issues instruction reads, buffers responses with their PCs, flushes on redirect
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  pcAddr,
  output logic         pcWre,
  output logic         imemEn,
  output logic [31:0]  imemAddr,
  input  logic [31:0]  imemData,
  input  logic         flush,
  output logic         instValid,
  output logic [31:0]  instData,
  output logic [31:0]  instPc,
  input  logic         instReady,
  output logic [PTR_W:0] count
);

  logic         pending;
  logic [31:0]  pendPc;
  logic         issue;
  logic         push;
  logic         pop;
  logic [PTR_W+1:0] occupancy;
  fetch_entry_t pushData;
  fetch_entry_t head;

  // Reservation counts the in-flight read but ignores same-cycle pops
  assign occupancy = {1'b0, count} + (PTR_W+2)'(pending);
  assign issue     = !reset && !flush && (occupancy < (PTR_W+2)'(DEPTH));

  assign imemEn   = issue;
  assign imemAddr = pcAddr;
  assign pcWre    = reset || flush || issue;

  assign instValid = (count != '0) && !flush && !reset;
  assign pop       = instValid && instReady;
  assign push      = pending && !flush && !reset;

  assign pushData.pc   = pendPc;
  assign pushData.inst = imemData;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      pendPc  <= RESET_PC;
    end else if (flush) begin
      pending <= 1'b0;
    end else begin
      pending <= issue;
      if (issue) pendPc <= pcAddr;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .push     (push),
    .pushData (pushData),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  assign instData = head.inst;
  assign instPc   = head.pc;

endmodule
